// File: rtl/qspi_pkg.sv
// qspi_pkg: shared command codes, nibble counts and FSM states for the QSPI responder
package qspi_pkg;
  localparam logic [7:0] CMD_QUAD_READ = 8'hEB;
  localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;
  localparam int ADDR_NIBBLES = 6;
  localparam int CMD_NIBBLES = 2;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE} state_t;
endpackage

// File: rtl/qspi_pin_sync.sv
// qspi_pin_sync: synchronizes the SPI pins and detects spi_clk edges
module qspi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_select_n,
  input  logic [3:0] spi_data_in,
  output logic       sel_n,
  output logic [3:0] data,
  output logic       clk_rise,
  output logic       clk_fall
);
  logic [5:0] q [SYNC_STAGES];
  logic clk_d;
  // all pins share one chain so data stays aligned with the clock edge; select resets asserted so a held-low select cannot look like a fresh assertion
  always_ff @(posedge clock)
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) q[i] <= '0;
      clk_d <= 1'b0;
    end else begin
      q[0] <= {spi_clk, spi_select_n, spi_data_in};
      for (int i = 1; i < SYNC_STAGES; i++) q[i] <= q[i-1];
      clk_d <= q[SYNC_STAGES-1][5];
    end
  assign sel_n = q[SYNC_STAGES-1][4];
  assign data = q[SYNC_STAGES-1][3:0];
  assign clk_rise = q[SYNC_STAGES-1][5] & ~clk_d;
  assign clk_fall = ~q[SYNC_STAGES-1][5] & clk_d;
endmodule

// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder: QPI command/address/data target serving a byte-wide memory port
module qspi_ram_responder
  import qspi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH = 8,
  parameter int DUMMY_NIBBLES = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      spi_clk,
  input  logic                      spi_select_n,
  input  logic [3:0]                spi_data_in,
  output logic [3:0]                spi_data_out,
  output logic [3:0]                spi_data_oe,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata
);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIBBLES - 1);
  logic sel_n, clk_rise, clk_fall, sel_prev, lo, re_d;
  logic [3:0] nib, whi, rlo;
  logic [7:0] cmd, rbuf, cnt;
  state_t state;
  qspi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock(clock), .reset(reset), .spi_clk(spi_clk), .spi_select_n(spi_select_n),
    .spi_data_in(spi_data_in), .sel_n(sel_n), .data(nib), .clk_rise(clk_rise), .clk_fall(clk_fall)
  );
  // transaction FSM: nibbles shift in on rises, read data goes out on falls, deselect overrides everything
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      spi_data_out <= '0;
      spi_data_oe <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      re_d <= 1'b0;
      sel_prev <= 1'b0;
      lo <= 1'b0;
      cnt <= '0;
      cmd <= '0;
      whi <= '0;
      rlo <= '0;
      rbuf <= '0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      re_d <= mem_re;
      sel_prev <= sel_n;
      if (re_d) rbuf <= mem_rdata;
      if (mem_we) mem_addr <= mem_addr + ADDRESS_WIDTH'(1);
      if (sel_n) begin
        state <= IDLE;
        spi_data_oe <= '0;
        spi_data_out <= '0;
        lo <= 1'b0;
        cnt <= '0;
      end else case (state)
        IDLE: if (sel_prev) begin
          state <= CMD;
          cnt <= '0;
        end
        CMD: if (clk_rise) begin
          cmd <= {cmd[3:0], nib};
          cnt <= cnt + 8'd1;
          if (cnt == 8'(CMD_NIBBLES - 1)) begin
            cnt <= '0;
            state <= ({cmd[3:0], nib} == CMD_QUAD_READ || {cmd[3:0], nib} == CMD_QUAD_WRITE) ? ADDR : IGNORE;
          end
        end
        ADDR: if (clk_rise) begin
          mem_addr <= ADDRESS_WIDTH'({mem_addr, nib});
          cnt <= cnt + 8'd1;
          if (cnt == 8'(ADDR_NIBBLES - 1)) begin
            cnt <= '0;
            lo <= 1'b0;
            mem_re <= cmd != CMD_QUAD_WRITE;
            state <= cmd == CMD_QUAD_WRITE ? WRITE : DUMMY_NIBBLES == 0 ? READ : DUMMY;
          end
        end
        DUMMY: if (clk_rise) begin
          cnt <= cnt + 8'd1;
          if (cnt == DUMMY_LAST) begin
            cnt <= '0;
            state <= READ;
          end
        end
        READ: if (clk_fall) begin
          spi_data_oe <= 4'hF;
          spi_data_out <= lo ? rlo : rbuf[7:4];
          if (!lo) rlo <= rbuf[3:0];
          lo <= !lo;
        end else if (clk_rise && lo) begin
          mem_addr <= mem_addr + ADDRESS_WIDTH'(1);
          mem_re <= 1'b1;
        end
        WRITE: if (clk_rise) begin
          lo <= !lo;
          if (lo) begin
            mem_wdata <= {whi, nib};
            mem_we <= 1'b1;
          end else whi <= nib;
        end
        IGNORE: ;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_qspi_ram_responder.sv
// tb_qspi_ram_responder: directed QPI initiator with a byte memory and strobe log
module tb_qspi_ram_responder;
  import qspi_pkg::*;
  localparam int K_W = 0, K_R = 1, K_X = 2;
  typedef struct {
    int kind;
    logic [7:0] cmd;
    logic [23:0] addr;
    int n;
    int half;
    int nwe;
    int nre;
    logic [31:0] d;
    logic [63:0] ea;
  } vec_t;
  logic clock = 0, reset = 1, spi_clk = 0, spi_select_n = 1;
  logic [3:0] spi_data_in = 0, spi_data_out, spi_data_oe;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic mem_we, mem_re;
  logic [7:0] mem [0:65535];
  logic [15:0] wa [$];
  logic [7:0] wd [$];
  int we_n = 0, re_n = 0, both_n = 0, checks = 0, errors = 0, H = 5;
  logic [3:0] o1, e1, o2, e2;
  logic oe_bad;
  vec_t tab [10];
  vec_t v_abort_w, v_rd;
  qspi_ram_responder dut (
    .clock(clock), .reset(reset), .spi_clk(spi_clk), .spi_select_n(spi_select_n),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (mem_we) begin
      we_n <= we_n + 1;
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (mem_re) re_n <= re_n + 1;
    if (mem_we && mem_re) both_n <= both_n + 1;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask
  task automatic xfer(input logic [3:0] d);
    spi_data_in = d;
    cyc(H);
    spi_clk = 1;
    o1 = spi_data_out;
    e1 = spi_data_oe;
    cyc(H - 1);
    o2 = spi_data_out;
    e2 = spi_data_oe;
    cyc(1);
    spi_clk = 0;
  endtask
  task automatic send(input logic [3:0] d);
    xfer(d);
    if (e1 != 0 || e2 != 0) oe_bad = 1;
  endtask
  task automatic send_hdr(input logic [7:0] c, input logic [23:0] a);
    send(c[7:4]);
    send(c[3:0]);
    for (int i = 5; i >= 0; i--) send(a[4*i +: 4]);
  endtask
  task automatic run_vec(input vec_t v);
    int we0, re0, q0;
    logic [3:0] x;
    we0 = we_n;
    re0 = re_n;
    q0 = wa.size();
    oe_bad = 0;
    H = v.half;
    spi_select_n = 0;
    cyc(2);
    if (v.kind == K_X) begin
      send(v.cmd[7:4]);
      send(v.cmd[3:0]);
      for (int i = 0; i < 16; i++) send(4'(i));
    end else begin
      send_hdr(v.cmd, v.addr);
      if (v.kind == K_R) begin
        for (int i = 0; i < 6; i++) send(4'h0);
        for (int b = 0; b < v.n; b++)
          for (int h = 0; h < 2; h++) begin
            x = v.d[31-8*b-4*h -: 4];
            xfer(4'h0);
            chk("rd_nibble", {e1, o1, e2, o2}, {4'hF, x, 4'hF, x});
          end
      end else
        for (int b = 0; b < v.n; b++)
          for (int h = 0; h < 2; h++) send(v.d[31-8*b-4*h -: 4]);
    end
    spi_select_n = 1;
    cyc(6);
    chk("oe_quiet", oe_bad, 0);
    chk("we_count", we_n - we0, v.nwe);
    chk("re_count", re_n - re0, v.nre);
    for (int i = 0; i < v.nwe && q0 + i < wa.size(); i++) begin
      chk("we_addr", wa[q0+i], v.ea[63-16*i -: 16]);
      chk("we_data", wd[q0+i], v.d[31-8*i -: 8]);
    end
    chk("oe_deselect", spi_data_oe, 0);
    chk("state_idle", dut.state, IDLE);
  endtask
  initial begin
    int we0, re0;
    tab[0] = '{K_W, 8'h38, 24'h001234, 2, 5, 2, 0, 32'hA53C0000, 64'h1234_1235_0000_0000};
    tab[1] = '{K_R, 8'hEB, 24'h001234, 2, 5, 0, 3, 32'hA53C0000, 64'h0};
    tab[2] = '{K_W, 8'h38, 24'h00FFFF, 2, 5, 2, 0, 32'h11220000, 64'hFFFF_0000_0000_0000};
    tab[3] = '{K_R, 8'hEB, 24'h00FFFF, 2, 5, 0, 3, 32'h11220000, 64'h0};
    tab[4] = '{K_X, 8'h9F, 24'h000000, 0, 5, 0, 0, 32'h0, 64'h0};
    tab[5] = '{K_R, 8'hEB, 24'h001235, 1, 5, 0, 2, 32'h3C000000, 64'h0};
    tab[6] = '{K_W, 8'h38, 24'hAB0010, 1, 5, 1, 0, 32'h77000000, 64'h0010_0000_0000_0000};
    tab[7] = '{K_R, 8'hEB, 24'h000010, 1, 5, 0, 2, 32'h77000000, 64'h0};
    tab[8] = '{K_W, 8'h38, 24'h002000, 4, 5, 4, 0, 32'hDEADBEEF, 64'h2000_2001_2002_2003};
    tab[9] = '{K_R, 8'hEB, 24'h002000, 4, 4, 0, 5, 32'hDEADBEEF, 64'h0};
    v_abort_w = '{K_W, 8'h38, 24'h000000, 1, 5, 1, 0, 32'h42000000, 64'h0};
    v_rd = tab[1];
    cyc(3);
    chk("rst_out", spi_data_out, 0);
    chk("rst_oe", spi_data_oe, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_strobes", {mem_we, mem_re}, 0);
    chk("rst_state", dut.state, IDLE);
    reset = 0;
    cyc(6);
    for (int i = 0; i < 10; i++) run_vec(tab[i]);
    H = 5;
    we0 = we_n;
    spi_select_n = 0;
    cyc(2);
    send_hdr(8'h38, 24'h000000);
    send(4'h7);
    spi_select_n = 1;
    cyc(6);
    chk("abort_we", we_n - we0, 0);
    chk("abort_state", dut.state, IDLE);
    run_vec(v_abort_w);
    H = 5;
    spi_select_n = 0;
    cyc(2);
    send_hdr(8'hEB, 24'h001234);
    for (int i = 0; i < 6; i++) send(4'h0);
    xfer(4'h0);
    chk("pre_reset_nib", {e1, o1}, {4'hF, 4'hA});
    cyc(4);
    chk("pre_reset_oe", spi_data_oe, 4'hF);
    reset = 1;
    @(posedge clock);
    #1;
    chk("mid_reset_oe", spi_data_oe, 0);
    chk("mid_reset_strobes", {mem_we, mem_re}, 0);
    chk("mid_reset_state", dut.state, IDLE);
    @(negedge clock);
    reset = 0;
    we0 = we_n;
    re0 = re_n;
    oe_bad = 0;
    send_hdr(8'h38, 24'h000000);
    send(4'h9);
    send(4'h9);
    chk("held_sel_oe", oe_bad, 0);
    chk("held_sel_strobes", (we_n - we0) + (re_n - re0), 0);
    chk("held_sel_state", dut.state, IDLE);
    spi_select_n = 1;
    cyc(6);
    run_vec(v_rd);
    chk("we_re_exclusive", both_n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
